traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
Parametrised N-approach traffic signal sequencer, the successor to the fixed 4-way light controller. It drives per-approach vehicle lamps (red, yellow, green, left) and per-crosswalk pedestrian lamps. It adds latched pedestrian requests, one-hot manual approach preemption and a day/night mode with blinking yellow. It sits between the time-of-day clock (daynight input) and the LCD status path (phase, active_dir and remain outputs).

Parameters:
N_DIR, 4, number of approaches/crosswalks (2..8); DW = $clog2(N_DIR), with a minimum of 1
TICK_DIV, 50000000, clk cycles per 1 s tick (>=2)
GREEN_T, 10, green duration in ticks (1..255)
LEFT_T, 5, protected-left duration in ticks (1..255)
YELLOW_T, 3, yellow duration in ticks (1..255)
ALLRED_T, 2, all-red clearance in ticks (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
daynight  in  1  1=day sequencing, 0=night blink mode
bt_manual  in  N_DIR  manual preempt request, one bit per approach
ped_req  in  N_DIR  pedestrian request pulse per crosswalk
led_red  out  N_DIR  red lamp per approach
led_yellow  out  N_DIR  yellow lamp per approach
led_green  out  N_DIR  green lamp per approach
led_left  out  N_DIR  left-arrow lamp per approach
led_walk_red  out  N_DIR  pedestrian don't-walk lamp
led_walk_green  out  N_DIR  pedestrian walk lamp
phase  out  3  0=ALLRED 1=GREEN 2=LEFT 3=YELLOW 4=NIGHT
active_dir  out  DW  approach currently served
remain  out  8  ticks left in the current phase
tick  out  1  one-cycle 1 s strobe

Behaviour:
- Reset is synchronous, active-high, and takes effect at any time, including mid-phase. All outputs are registered. On the cycle after reset:
  - phase=ALLRED, active_dir=0, remain=ALLRED_T
  - led_red=all 1s, other vehicle lamps=0
  - led_walk_red=all 1s, led_walk_green=0
  - tick=0; prescaler, pending manual request and ped latches cleared
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for exactly the one cycle where count==TICK_DIV-1.
- Phase timing: remain is loaded with the phase duration on phase entry and decrements on tick. A tick with remain==1 causes the transition, so each phase lasts exactly its duration in ticks.
- Day sequence: ALLRED -> GREEN -> LEFT -> YELLOW -> ALLRED.
  - At YELLOW->ALLRED, active_dir becomes the pending manual target if one is valid, otherwise (active_dir+1) mod N_DIR.
- Lamps:
  - Active approach: green in GREEN, left in LEFT, yellow in YELLOW, otherwise red.
  - Every non-active approach shows red.
  - Exactly one vehicle lamp per approach is lit in day mode.
- Manual preempt:
  - Any nonzero bt_manual is captured as a pending target. The lowest set index wins. A new capture overwrites the previous pending target.
  - Target != active_dir while in GREEN or LEFT: next cycle go to YELLOW, remain=YELLOW_T.
  - Target == active_dir in GREEN: reload remain=GREEN_T and drop the request.
  - Otherwise the target is held and consumed at the next YELLOW->ALLRED.
  - Requests in NIGHT are ignored.
- Pedestrian:
  - ped_req bits set sticky latches (OR each cycle).
  - On GREEN entry, grant = latches & ~(1<<active_dir). led_walk_green=grant for the whole GREEN phase.
  - On GREEN exit, granted latches are cleared and led_walk_green returns to 0.
  - Requests arriving during GREEN are served at the next GREEN.
  - led_walk_red = ~led_walk_green at all times.
- Night entry (daynight=0 sampled):
  - In GREEN or LEFT: force YELLOW, remain=YELLOW_T.
  - In YELLOW or ALLRED: finish the current phase, then go to NIGHT.
  - NIGHT loads remain=1 and reloads it every tick. led_yellow toggles all-1s/all-0s on each tick, starting at all-1s. Red, green and left are 0. Walk lamps are all red. Ped latches are held.
- Night exit: daynight=1 while in NIGHT goes to ALLRED on the next cycle, with active_dir=0 and remain=ALLRED_T.
- Simultaneous events: reset > night entry > manual preempt > timer expiry. A preempt and expiry on the same cycle take the YELLOW path once, without double-counting.

Test Plan:
(All scenarios use N_DIR=4, TICK_DIV=4, GREEN_T=5, LEFT_T=3, YELLOW_T=2, ALLRED_T=1.)
1. Free run after reset, daynight=1 -> dir0 green for 20 cycles, left 12, yellow 8, allred 4, then dir1 green; dir0 green again 176 cycles after its first green start; led_red[3:1]=1 throughout dir0.
2. bt_manual=4'b0100 pulse during dir0 GREEN (remain=4) -> phase=YELLOW next cycle, remain=2; after YELLOW+ALLRED, active_dir=2 and dir1 is skipped.
3. bt_manual=4'b1010 in one cycle during dir0 LEFT -> target dir1; bt_manual=4'b0001 during dir0 GREEN -> remain reloads to 5.
4. ped_req=4'b1001 pulse during dir1 ALLRED -> dir1 GREEN shows led_walk_green=4'b1001 for 20 cycles, then 0; both latches cleared.
5. ped_req[2] during dir2 ALLRED -> no walk in dir2 GREEN; walk_green[2]=1 in dir3 GREEN.
6. daynight 1->0 in dir0 GREEN -> YELLOW for 2 ticks, then NIGHT with led_yellow alternating 4'b1111/4'b0000 per tick; daynight->1 gives ALLRED with active_dir=0 next cycle; rst pulse mid-LEFT restores all reset values on the next edge.

Source files
------------

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic signal sequencer: day cycle ALLRED -> GREEN -> LEFT ->
// YELLOW per approach, latched pedestrian requests, one-hot manual preemption
// and a night blink mode. The phase output is the FSM state register.
module traffic_phase_ctrl #(
    parameter int N_DIR    = 4,
    parameter int TICK_DIV = 50000000,
    parameter int GREEN_T  = 10,
    parameter int LEFT_T   = 5,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    localparam int DW      = (N_DIR > 2) ? $clog2(N_DIR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             daynight,
    input  logic [N_DIR-1:0] bt_manual,
    input  logic [N_DIR-1:0] ped_req,
    output logic [N_DIR-1:0] led_red,
    output logic [N_DIR-1:0] led_yellow,
    output logic [N_DIR-1:0] led_green,
    output logic [N_DIR-1:0] led_left,
    output logic [N_DIR-1:0] led_walk_red,
    output logic [N_DIR-1:0] led_walk_green,
    output logic [2:0]       phase,
    output logic [DW-1:0]    active_dir,
    output logic [7:0]       remain,
    output logic             tick
);
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        PH_ALLRED = 3'd0,
        PH_GREEN  = 3'd1,
        PH_LEFT   = 3'd2,
        PH_YELLOW = 3'd3,
        PH_NIGHT  = 3'd4
    } phase_t;

    phase_t           state, nxt_state;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             man_valid, nxt_mv;
    logic [DW-1:0]    man_tgt, nxt_mt, man_low, eff_tgt, dir_inc, nxt_dir;
    logic             eff_valid, expire, green_exit;
    logic [N_DIR-1:0] ped_lat, nxt_lat, grant, nxt_grant, dir_mask, nxt_mask;
    logic [N_DIR-1:0] l_red, l_yel, l_grn, l_left, l_walk;
    logic             blink, nxt_blink;
    logic [7:0]       nxt_remain;

    assign phase     = state;
    assign cnt_nxt   = (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
    assign expire    = tick && (remain == 8'd1);
    assign dir_mask  = N_DIR'(1) << active_dir;
    assign dir_inc   = (active_dir == DW'(N_DIR - 1)) ? '0 : active_dir + DW'(1);
    // A request on the current cycle overrides any older pending target.
    assign eff_valid = (|bt_manual) | man_valid;
    assign eff_tgt   = (|bt_manual) ? man_low : man_tgt;

    // Lowest set bt_manual bit wins the preempt target.
    always_comb begin
        man_low = '0;
        for (int i = N_DIR - 1; i >= 0; i--) begin
            if (bt_manual[i]) man_low = DW'(i);
        end
    end

    // Next-state logic; branch order encodes night > preempt > expiry.
    always_comb begin
        nxt_state  = state;
        nxt_remain = remain;
        nxt_dir    = active_dir;
        nxt_mv     = man_valid;
        nxt_mt     = man_tgt;
        nxt_lat    = ped_lat | ped_req;
        nxt_grant  = grant;
        nxt_blink  = blink;
        green_exit = 1'b0;
        if ((state != PH_NIGHT) && (|bt_manual)) begin
            nxt_mv = 1'b1;
            nxt_mt = man_low;
        end
        case (state)
            PH_ALLRED: begin
                if (expire) begin
                    if (!daynight) begin
                        nxt_state  = PH_NIGHT;
                        nxt_remain = 8'd1;
                        nxt_blink  = 1'b1;
                    end else begin
                        nxt_state  = PH_GREEN;
                        nxt_remain = 8'(GREEN_T);
                        nxt_grant  = (ped_lat | ped_req) & ~dir_mask;
                    end
                end else if (tick) begin
                    nxt_remain = remain - 8'd1;
                end
            end
            PH_GREEN: begin
                if (!daynight || (eff_valid && (eff_tgt != active_dir))) begin
                    nxt_state  = PH_YELLOW;
                    nxt_remain = 8'(YELLOW_T);
                    green_exit = 1'b1;
                end else if (eff_valid) begin
                    // Preempt for the approach already green: extend and drop it.
                    nxt_remain = 8'(GREEN_T);
                    nxt_mv     = 1'b0;
                end else if (expire) begin
                    nxt_state  = PH_LEFT;
                    nxt_remain = 8'(LEFT_T);
                    green_exit = 1'b1;
                end else if (tick) begin
                    nxt_remain = remain - 8'd1;
                end
            end
            PH_LEFT: begin
                if (!daynight || (eff_valid && (eff_tgt != active_dir)) || expire) begin
                    nxt_state  = PH_YELLOW;
                    nxt_remain = 8'(YELLOW_T);
                end else if (tick) begin
                    nxt_remain = remain - 8'd1;
                end
            end
            PH_YELLOW: begin
                if (expire) begin
                    if (!daynight) begin
                        nxt_state  = PH_NIGHT;
                        nxt_remain = 8'd1;
                        nxt_blink  = 1'b1;
                    end else begin
                        nxt_state  = PH_ALLRED;
                        nxt_remain = 8'(ALLRED_T);
                        nxt_dir    = eff_valid ? eff_tgt : dir_inc;
                        nxt_mv     = 1'b0;
                    end
                end else if (tick) begin
                    nxt_remain = remain - 8'd1;
                end
            end
            PH_NIGHT: begin
                if (daynight) begin
                    nxt_state  = PH_ALLRED;
                    nxt_remain = 8'(ALLRED_T);
                    nxt_dir    = '0;
                    nxt_blink  = 1'b0;
                end else if (tick) begin
                    nxt_remain = 8'd1;
                    nxt_blink  = ~blink;
                end
            end
            default: nxt_state = PH_ALLRED;
        endcase
        if (green_exit) begin
            nxt_lat   = (ped_lat | ped_req) & ~grant;
            nxt_grant = '0;
        end
    end

    // Lamp pattern decoded from the next state so the lamps register with it.
    always_comb begin
        nxt_mask = N_DIR'(1) << nxt_dir;
        l_red    = '1;
        l_yel    = '0;
        l_grn    = '0;
        l_left   = '0;
        l_walk   = '0;
        case (nxt_state)
            PH_GREEN: begin
                l_red  = ~nxt_mask;
                l_grn  = nxt_mask;
                l_walk = nxt_grant;
            end
            PH_LEFT: begin
                l_red  = ~nxt_mask;
                l_left = nxt_mask;
            end
            PH_YELLOW: begin
                l_red = ~nxt_mask;
                l_yel = nxt_mask;
            end
            PH_NIGHT: begin
                l_red = '0;
                l_yel = {N_DIR{nxt_blink}};
            end
            default: ;
        endcase
    end

    // State, prescaler and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            tick           <= 1'b0;
            state          <= PH_ALLRED;
            active_dir     <= '0;
            remain         <= 8'(ALLRED_T);
            man_valid      <= 1'b0;
            man_tgt        <= '0;
            ped_lat        <= '0;
            grant          <= '0;
            blink          <= 1'b0;
            led_red        <= '1;
            led_yellow     <= '0;
            led_green      <= '0;
            led_left       <= '0;
            led_walk_red   <= '1;
            led_walk_green <= '0;
        end else begin
            cnt            <= cnt_nxt;
            tick           <= (cnt_nxt == CW'(TICK_DIV - 1));
            state          <= nxt_state;
            active_dir     <= nxt_dir;
            remain         <= nxt_remain;
            man_valid      <= nxt_mv;
            man_tgt        <= nxt_mt;
            ped_lat        <= nxt_lat;
            grant          <= nxt_grant;
            blink          <= nxt_blink;
            led_red        <= l_red;
            led_yellow     <= l_yel;
            led_green      <= l_grn;
            led_left       <= l_left;
            led_walk_red   <= ~l_walk;
            led_walk_green <= l_walk;
        end
    end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl with short timing parameters. Expected phase
// segments {phase, dir, length} are queued per scenario and compared as each
// segment ends; point checks cover preemption, pedestrians and night mode.
module tb_traffic_phase_ctrl;
    localparam logic [2:0] P_AR = 3'd0;
    localparam logic [2:0] P_G  = 3'd1;
    localparam logic [2:0] P_L  = 3'd2;
    localparam logic [2:0] P_Y  = 3'd3;
    localparam logic [2:0] P_N  = 3'd4;

    logic       clk, rst, daynight;
    logic [3:0] bt_manual, ped_req;
    logic [3:0] led_red, led_yellow, led_green, led_left, led_walk_red, led_walk_green;
    logic [2:0] phase;
    logic [1:0] active_dir;
    logic [7:0] remain;
    logic       tick;

    int tests_run, fail_cnt, cyc, tick_cnt, walk_on, walk_viol, lamp_viol, red_viol, seg_no;
    logic [2:0]  mon_ph;
    logic [1:0]  mon_dir;
    int          mon_len;
    logic [20:0] exp_q[$];

    traffic_phase_ctrl #(
        .N_DIR(4), .TICK_DIV(4), .GREEN_T(5), .LEFT_T(3), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk(clk), .rst(rst), .daynight(daynight), .bt_manual(bt_manual), .ped_req(ped_req),
        .led_red(led_red), .led_yellow(led_yellow), .led_green(led_green), .led_left(led_left),
        .led_walk_red(led_walk_red), .led_walk_green(led_walk_green),
        .phase(phase), .active_dir(active_dir), .remain(remain), .tick(tick)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_seg(input logic [2:0] ph, input logic [1:0] d, input int len);
        exp_q.push_back({ph, d, 16'(len)});
    endtask

    // One clock: sample #1 after the edge, track invariants and segments.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!rst) begin
            if (led_walk_red !== ~led_walk_green) walk_viol++;
            if (led_walk_green != 4'b0000) walk_on++;
            if (tick) tick_cnt++;
            if (phase != P_N) begin
                for (int i = 0; i < 4; i++) begin
                    if ($countones({led_red[i], led_yellow[i], led_green[i], led_left[i]}) != 1)
                        lamp_viol++;
                end
                if (active_dir == 2'd0 && led_red[3:1] != 3'b111) red_viol++;
            end
            if (phase == mon_ph && active_dir == mon_dir) begin
                mon_len++;
            end else begin
                if (exp_q.size() > 0) begin
                    check($sformatf("seg%0d_phase", seg_no), 32'(mon_ph), 32'(exp_q[0][20:18]));
                    check($sformatf("seg%0d_dir", seg_no), 32'(mon_dir), 32'(exp_q[0][17:16]));
                    check($sformatf("seg%0d_len", seg_no), 32'(mon_len), 32'(exp_q[0][15:0]));
                    void'(exp_q.pop_front());
                    seg_no++;
                end
                mon_ph  = phase;
                mon_dir = active_dir;
                mon_len = 1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst      = 1'b0;
        cyc      = 0;
        mon_ph   = P_AR;
        mon_dir  = 2'd0;
        mon_len  = 1;
        tick_cnt = 0;
        walk_on  = 0;
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_phase"}, 32'(phase), 32'(P_AR));
        check({pfx, "_dir"}, 32'(active_dir), 32'd0);
        check({pfx, "_remain"}, 32'(remain), 32'd1);
        check({pfx, "_red"}, 32'(led_red), 32'hF);
        check({pfx, "_yellow"}, 32'(led_yellow), 32'h0);
        check({pfx, "_green"}, 32'(led_green), 32'h0);
        check({pfx, "_left"}, 32'(led_left), 32'h0);
        check({pfx, "_walk_red"}, 32'(led_walk_red), 32'hF);
        check({pfx, "_walk_green"}, 32'(led_walk_green), 32'h0);
        check({pfx, "_tick"}, 32'(tick), 32'd0);
    endtask

    // Driver and scenarios
    initial begin
        int ped_cyc;
        tests_run = 0; fail_cnt = 0; cyc = 0; seg_no = 0;
        walk_viol = 0; lamp_viol = 0; red_viol = 0;
        rst = 1'b1; daynight = 1'b1; bt_manual = 4'b0; ped_req = 4'b0;

        // Free run: full four-approach rotation back to dir0 green.
        do_reset(3);
        check_reset("rst");
        push_seg(P_AR, 2'd0, 4);
        for (int d = 0; d < 4; d++) begin
            push_seg(P_G, 2'(d), 20);
            push_seg(P_L, 2'(d), 12);
            push_seg(P_Y, 2'(d), 8);
            push_seg(P_AR, 2'((d + 1) % 4), 4);
        end
        goto(2);
        check("tick_c2", 32'(tick), 32'd0);
        goto(3);
        check("tick_c3", 32'(tick), 32'd1);
        goto(4);
        check("green_c4_remain", 32'(remain), 32'd5);
        check("green_c4_lamp", 32'(led_green), 32'b0001);
        check("green_c4_red", 32'(led_red), 32'b1110);
        goto(44);
        check("tick_count_44", 32'(tick_cnt), 32'd11);
        goto(180);
        check("dir0_again_phase", 32'(phase), 32'(P_G));
        check("dir0_again_dir", 32'(active_dir), 32'd0);
        wait_drain(10);

        // Preempt to dir2 during dir0 green.
        do_reset(2);
        push_seg(P_AR, 2'd0, 4);  push_seg(P_G, 2'd0, 6);   push_seg(P_Y, 2'd0, 6);
        push_seg(P_AR, 2'd2, 4);  push_seg(P_G, 2'd2, 20);  push_seg(P_L, 2'd2, 12);
        push_seg(P_Y, 2'd2, 8);   push_seg(P_AR, 2'd3, 4);
        goto(9);
        check("pre_remain", 32'(remain), 32'd4);
        bt_manual = 4'b0100;
        goto(10);
        bt_manual = 4'b0;
        check("preempt_phase", 32'(phase), 32'(P_Y));
        check("preempt_remain", 32'(remain), 32'd2);
        goto(16);
        check("preempt_dir", 32'(active_dir), 32'd2);
        wait_drain(80);

        // Two-bit request in LEFT resolves to lowest index.
        do_reset(2);
        push_seg(P_AR, 2'd0, 4);  push_seg(P_G, 2'd0, 20);  push_seg(P_L, 2'd0, 3);
        push_seg(P_Y, 2'd0, 5);   push_seg(P_AR, 2'd1, 4);
        goto(26);
        check("left_phase", 32'(phase), 32'(P_L));
        bt_manual = 4'b1010;
        goto(27);
        bt_manual = 4'b0;
        check("left_pre_phase", 32'(phase), 32'(P_Y));
        check("left_pre_remain", 32'(remain), 32'd2);
        wait_drain(20);

        // Preempt for the approach already green extends it and is dropped.
        do_reset(2);
        push_seg(P_AR, 2'd0, 4);  push_seg(P_G, 2'd0, 28);  push_seg(P_L, 2'd0, 12);
        push_seg(P_Y, 2'd0, 8);   push_seg(P_AR, 2'd1, 4);
        goto(13);
        check("self_pre_remain_before", 32'(remain), 32'd3);
        bt_manual = 4'b0001;
        goto(14);
        bt_manual = 4'b0;
        check("self_pre_phase", 32'(phase), 32'(P_G));
        check("self_pre_remain", 32'(remain), 32'd5);
        wait_drain(60);

        // Pedestrian grants, masking of own crosswalk, deferred service.
        do_reset(2);
        ped_cyc = $urandom_range(44, 46);
        goto(ped_cyc);
        ped_req = 4'b1001;
        goto(ped_cyc + 1);
        ped_req = 4'b0;
        goto(47);
        check("walk_before_green", 32'(led_walk_green), 32'h0);
        goto(48);
        check("walk_d1_dir", 32'(active_dir), 32'd1);
        check("walk_d1_green", 32'(led_walk_green), 32'b1001);
        goto(68);
        check("walk_d1_end", 32'(led_walk_green), 32'h0);
        check("walk_d1_cycles", 32'(walk_on), 32'd20);
        goto(89);
        ped_req = 4'b0100;
        goto(90);
        ped_req = 4'b0;
        goto(92);
        check("walk_d2_phase", 32'(phase), 32'(P_G));
        check("walk_d2_green", 32'(led_walk_green), 32'h0);
        goto(100);
        ped_req = 4'b0001;
        goto(101);
        ped_req = 4'b0;
        check("walk_d2_late", 32'(led_walk_green), 32'h0);
        goto(136);
        check("walk_d3_dir", 32'(active_dir), 32'd3);
        check("walk_d3_green", 32'(led_walk_green), 32'b0101);
        goto(156);
        check("walk_d3_end", 32'(led_walk_green), 32'h0);
        check("walk_total_cycles", 32'(walk_on), 32'd40);

        // Night entry from green, blink, ignored preempt, exit, mid-LEFT reset.
        do_reset(2);
        goto(5);
        ped_req = 4'b0100;
        goto(6);
        ped_req = 4'b0;
        goto(10);
        daynight = 1'b0;
        goto(11);
        check("night_yellow_phase", 32'(phase), 32'(P_Y));
        check("night_yellow_remain", 32'(remain), 32'd2);
        goto(16);
        check("night_phase", 32'(phase), 32'(P_N));
        check("night_remain", 32'(remain), 32'd1);
        check("night_blink0", 32'(led_yellow), 32'hF);
        check("night_red", 32'(led_red), 32'h0);
        check("night_green", 32'(led_green | led_left), 32'h0);
        check("night_walk_red", 32'(led_walk_red), 32'hF);
        goto(18);
        bt_manual = 4'b0100;
        goto(19);
        bt_manual = 4'b0;
        for (int k = 1; k <= 3; k++) begin
            goto(16 + 4 * k);
            check($sformatf("night_blink%0d", k), 32'(led_yellow), (k % 2 == 1) ? 32'h0 : 32'hF);
        end
        check("night_remain_hold", 32'(remain), 32'd1);
        goto(30);
        daynight = 1'b1;
        goto(31);
        check("day_exit_phase", 32'(phase), 32'(P_AR));
        check("day_exit_dir", 32'(active_dir), 32'd0);
        check("day_exit_remain", 32'(remain), 32'd1);
        check("day_exit_red", 32'(led_red), 32'hF);
        check("day_exit_yellow", 32'(led_yellow), 32'h0);
        goto(32);
        check("day_green_phase", 32'(phase), 32'(P_G));
        check("day_green_walk_held", 32'(led_walk_green), 32'b0100);
        goto(40);
        check("night_manual_ignored", 32'(phase), 32'(P_G));
        goto(53);
        check("mid_left_phase", 32'(phase), 32'(P_L));
        ped_req = 4'b0100;
        goto(54);
        ped_req = 4'b0;
        goto(55);
        do_reset(1);
        check_reset("midrst");
        goto(2);
        check("midrst_tick_c2", 32'(tick), 32'd0);
        goto(3);
        check("midrst_tick_c3", 32'(tick), 32'd1);
        goto(4);
        check("midrst_green", 32'(phase), 32'(P_G));
        check("midrst_ped_cleared", 32'(led_walk_green), 32'h0);

        // Invariants accumulated over the whole run
        check("walk_complement", 32'(walk_viol), 32'd0);
        check("one_lamp_per_approach", 32'(lamp_viol), 32'd0);
        check("others_red_dir0", 32'(red_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end
endmodule
